// File: rtl/lsu_seq_ctrl.sv
// Multi-cycle sequencer for RV32I loads/stores: owns the PC stall, issues LSU
// read/write strobes (read-modify-write for sb/sh) and gates rd writeback.
module lsu_seq_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_insn_vld,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_mem_rvalid,
    output logic       o_pc_stall,
    output logic       o_mem_rden,
    output logic       o_mem_wren,
    output logic       o_ld_capture,
    output logic       o_rd_wren_en,
    output logic       o_busy,
    output logic       o_err,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RD_WAIT   = 2'd1,
        S_WR_COMMIT = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        C_NONMEM = 2'd0,
        C_LOAD   = 2'd1,
        C_SW     = 2'd2,
        C_SUB    = 2'd3
    } cls_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t     state, state_nx;
    cls_t       cls, dec_cls;
    logic [7:0] cnt;
    logic       timed_out;
    logic       err;

    logic       stall_c, rden_c, wren_c, cap_c, rdw_c;
    logic       cnt_clr, cnt_inc, set_to, cls_ld;
    logic [8:0] cnt_plus1;
    logic       timeout_hit;

    // Decode of the live instruction; only consulted while IDLE.
    always_comb begin
        dec_cls = C_NONMEM;
        if (i_insn_vld) begin
            if (i_opcode == OP_LOAD) begin
                dec_cls = C_LOAD;
            end else if (i_opcode == OP_STORE) begin
                if (i_funct3 == 3'b010) begin
                    dec_cls = C_SW;
                end else if (i_funct3 == 3'b000 || i_funct3 == 3'b001) begin
                    dec_cls = C_SUB;
                end
            end
        end
    end

    // Timeout fires on the RD_WAIT cycle whose count would reach TIMEOUT.
    assign cnt_plus1   = {1'b0, cnt} + 9'd1;
    assign timeout_hit = (cnt_plus1 >= 9'(TIMEOUT));

    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        rden_c   = 1'b0;
        wren_c   = 1'b0;
        cap_c    = 1'b0;
        rdw_c    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        set_to   = 1'b0;
        cls_ld   = 1'b0;
        case (state)
            S_IDLE: begin
                rdw_c = 1'b1;
                case (dec_cls)
                    C_LOAD, C_SUB: begin
                        stall_c  = 1'b1;
                        rden_c   = 1'b1;
                        rdw_c    = 1'b0;
                        cnt_clr  = 1'b1;
                        cls_ld   = 1'b1;
                        state_nx = S_RD_WAIT;
                    end
                    C_SW: begin
                        stall_c  = 1'b1;
                        wren_c   = 1'b1;
                        rdw_c    = 1'b0;
                        cls_ld   = 1'b1;
                        state_nx = S_DONE;
                    end
                    default: ;
                endcase
            end
            S_RD_WAIT: begin
                stall_c = 1'b1;
                // rvalid takes priority over a coincident timeout.
                if (i_mem_rvalid) begin
                    cap_c    = 1'b1;
                    state_nx = (cls == C_SUB) ? S_WR_COMMIT : S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    if (timeout_hit) begin
                        set_to   = 1'b1;
                        state_nx = S_DONE;
                    end
                end
            end
            S_WR_COMMIT: begin
                stall_c  = 1'b1;
                wren_c   = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                rdw_c    = (cls == C_LOAD) && !timed_out;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cls       <= C_NONMEM;
            cnt       <= 8'd0;
            timed_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            if (cls_ld) begin
                cls       <= dec_cls;
                timed_out <= 1'b0;
            end
            if (cnt_clr) begin
                cnt <= 8'd0;
            end else if (cnt_inc && cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
            if (set_to) begin
                timed_out <= 1'b1;
                err       <= 1'b1;
            end
        end
    end

    // Reset forces a safe output set: PC held, no strobes, no writeback.
    assign o_pc_stall   = i_rst ? 1'b1 : stall_c;
    assign o_mem_rden   = i_rst ? 1'b0 : rden_c;
    assign o_mem_wren   = i_rst ? 1'b0 : wren_c;
    assign o_ld_capture = i_rst ? 1'b0 : cap_c;
    assign o_rd_wren_en = i_rst ? 1'b0 : rdw_c;
    assign o_busy       = i_rst ? 1'b0 : (state != S_IDLE);
    assign o_state      = i_rst ? 2'd0 : state;
    assign o_err        = err;

endmodule

// File: tb/tb_lsu_seq_ctrl.sv
// Directed bench for lsu_seq_ctrl (TIMEOUT=4); per-cycle output vectors are hand-derived.
module tb_lsu_seq_ctrl;

    logic       i_clk;
    logic       i_rst;
    logic       i_insn_vld;
    logic [6:0] i_opcode;
    logic [2:0] i_funct3;
    logic       i_mem_rvalid;
    logic       o_pc_stall, o_mem_rden, o_mem_wren, o_ld_capture;
    logic       o_rd_wren_en, o_busy, o_err;
    logic [1:0] o_state;

    int n_checks;
    int n_fail;

    // {stall, rden, wren, ld_capture, rd_wren_en, busy, err, state[1:0]}
    logic [8:0] obs;
    assign obs = {o_pc_stall, o_mem_rden, o_mem_wren, o_ld_capture,
                  o_rd_wren_en, o_busy, o_err, o_state};

    localparam int I_NOP  = 0;
    localparam int I_LW   = 1;
    localparam int I_SB   = 2;
    localparam int I_SW   = 3;
    localparam int I_ADD  = 4;
    localparam int I_ADDI = 5;

    lsu_seq_ctrl #(.TIMEOUT(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_insn_vld   (i_insn_vld),
        .i_opcode     (i_opcode),
        .i_funct3     (i_funct3),
        .i_mem_rvalid (i_mem_rvalid),
        .o_pc_stall   (o_pc_stall),
        .o_mem_rden   (o_mem_rden),
        .o_mem_wren   (o_mem_wren),
        .o_ld_capture (o_ld_capture),
        .o_rd_wren_en (o_rd_wren_en),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_state      (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic set_insn(input int id);
        i_insn_vld = 1'b1;
        i_funct3   = 3'b000;
        case (id)
            I_LW:    begin i_opcode = 7'b0000011; i_funct3 = 3'b010; end
            I_SB:    begin i_opcode = 7'b0100011; i_funct3 = 3'b000; end
            I_SW:    begin i_opcode = 7'b0100011; i_funct3 = 3'b010; end
            I_ADD:   i_opcode = 7'b0110011;
            I_ADDI:  i_opcode = 7'b0010011;
            default: begin i_insn_vld = 1'b0; i_opcode = 7'b0000011; end
        endcase
    endtask

    // One cycle: inputs change just after the rising edge, outputs sampled on the falling edge.
    task automatic drive(input int id, input logic rv);
        @(posedge i_clk);
        #1;
        set_insn(id);
        i_mem_rvalid = rv;
        @(negedge i_clk);
    endtask

    task automatic pulse_reset();
        set_insn(I_NOP);
        i_mem_rvalid = 1'b0;
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    task automatic test_reset();
        set_insn(I_LW);
        i_mem_rvalid = 1'b0;
        #2;
        n_checks++;
        if (obs !== 9'b1_0_0_0_0_0_0_00) begin
            n_fail++;
            $display("FAIL reset_forced got=%b exp=%b", obs, 9'b1_0_0_0_0_0_0_00);
        end
        set_insn(I_NOP);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        drive(I_LW, 1'b0);
        drive(I_LW, 1'b0);
        n_checks++;
        if (obs !== 9'b1_0_0_0_0_1_0_01) begin
            n_fail++;
            $display("FAIL reset_pre_rdwait got=%b exp=%b", obs, 9'b1_0_0_0_0_1_0_01);
        end
        #1 i_rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 9'b1_0_0_0_0_0_0_00) begin
            n_fail++;
            $display("FAIL reset_mid_rdwait got=%b exp=%b", obs, 9'b1_0_0_0_0_0_0_00);
        end
        set_insn(I_NOP);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        drive(I_ADD, 1'b0);
        n_checks++;
        if (obs !== 9'b0_0_0_0_1_0_0_00) begin
            n_fail++;
            $display("FAIL reset_release got=%b exp=%b", obs, 9'b0_0_0_0_1_0_0_00);
        end
    endtask

    task automatic test_lw();
        int         ins[4] = '{I_LW, I_LW, I_LW, I_NOP};
        logic       rv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [8:0] ex[4]  = '{9'b1_1_0_0_0_0_0_00, 9'b1_0_0_1_0_1_0_01,
                               9'b0_0_0_0_1_1_0_11, 9'b0_0_0_0_1_0_0_00};
        int nr = 0, nw = 0;
        for (int i = 0; i < 4; i++) begin
            drive(ins[i], rv[i]);
            nr += int'(o_mem_rden);
            nw += int'(o_mem_wren);
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL lw_cyc%0d got=%b exp=%b", i, obs, ex[i]);
            end
        end
        n_checks++;
        if (nr != 1 || nw != 0) begin
            n_fail++;
            $display("FAIL lw_pulses got rden=%0d wren=%0d exp rden=1 wren=0", nr, nw);
        end
    endtask

    task automatic test_sb();
        int         ins[7] = '{I_SB, I_SB, I_SB, I_SB, I_SB, I_SB, I_NOP};
        logic       rv[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [8:0] ex[7]  = '{9'b1_1_0_0_0_0_0_00, 9'b1_0_0_0_0_1_0_01,
                               9'b1_0_0_0_0_1_0_01, 9'b1_0_0_1_0_1_0_01,
                               9'b1_0_1_0_0_1_0_10, 9'b0_0_0_0_0_1_0_11,
                               9'b0_0_0_0_1_0_0_00};
        int nr = 0, nw = 0;
        for (int i = 0; i < 7; i++) begin
            drive(ins[i], rv[i]);
            nr += int'(o_mem_rden);
            nw += int'(o_mem_wren);
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL sb_cyc%0d got=%b exp=%b", i, obs, ex[i]);
            end
        end
        n_checks++;
        if (nr != 1 || nw != 1) begin
            n_fail++;
            $display("FAIL sb_pulses got rden=%0d wren=%0d exp rden=1 wren=1", nr, nw);
        end
    endtask

    task automatic test_sw();
        int         ins[3] = '{I_SW, I_SW, I_NOP};
        logic [8:0] ex[3]  = '{9'b1_0_1_0_0_0_0_00, 9'b0_0_0_0_0_1_0_11,
                               9'b0_0_0_0_1_0_0_00};
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], 1'b0);
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL sw_cyc%0d got=%b exp=%b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int         ins[7] = '{I_ADD, I_LW, I_LW, I_LW, I_LW, I_ADDI, I_NOP};
        logic       rv[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [8:0] ex[7]  = '{9'b0_0_0_0_1_0_0_00, 9'b1_1_0_0_0_0_0_00,
                               9'b1_0_0_0_0_1_0_01, 9'b1_0_0_1_0_1_0_01,
                               9'b0_0_0_0_1_1_0_11, 9'b0_0_0_0_1_0_0_00,
                               9'b0_0_0_0_1_0_0_00};
        for (int i = 0; i < 7; i++) begin
            drive(ins[i], rv[i]);
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL b2b_cyc%0d got=%b exp=%b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int         ins[7] = '{I_LW, I_LW, I_LW, I_LW, I_LW, I_LW, I_NOP};
        logic [8:0] ex_to[7] = '{9'b1_1_0_0_0_0_0_00, 9'b1_0_0_0_0_1_0_01,
                                 9'b1_0_0_0_0_1_0_01, 9'b1_0_0_0_0_1_0_01,
                                 9'b1_0_0_0_0_1_0_01, 9'b0_0_0_0_0_1_1_11,
                                 9'b0_0_0_0_1_0_1_00};
        logic       rv_ok[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [8:0] ex_ok[4] = '{9'b1_1_0_0_0_0_1_00, 9'b1_0_0_1_0_1_1_01,
                                 9'b0_0_0_0_1_1_1_11, 9'b0_0_0_0_1_0_1_00};
        logic       rv_ed[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [8:0] ex_ed[7] = '{9'b1_1_0_0_0_0_0_00, 9'b1_0_0_0_0_1_0_01,
                                 9'b1_0_0_0_0_1_0_01, 9'b1_0_0_0_0_1_0_01,
                                 9'b1_0_0_1_0_1_0_01, 9'b0_0_0_0_1_1_0_11,
                                 9'b0_0_0_0_1_0_0_00};
        for (int i = 0; i < 7; i++) begin
            drive(ins[i], 1'b0);
            n_checks++;
            if (obs !== ex_to[i]) begin
                n_fail++;
                $display("FAIL timeout_cyc%0d got=%b exp=%b", i, obs, ex_to[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive((i == 3) ? I_NOP : I_LW, rv_ok[i]);
            n_checks++;
            if (obs !== ex_ok[i]) begin
                n_fail++;
                $display("FAIL sticky_err_cyc%0d got=%b exp=%b", i, obs, ex_ok[i]);
            end
        end
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            drive(ins[i], rv_ed[i]);
            n_checks++;
            if (obs !== ex_ed[i]) begin
                n_fail++;
                $display("FAIL rvalid_at_edge_cyc%0d got=%b exp=%b", i, obs, ex_ed[i]);
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        i_rst        = 1'b1;
        i_mem_rvalid = 1'b0;
        set_insn(I_NOP);
        test_reset();
        test_lw();
        test_sb();
        test_sw();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
